regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Receiving end of the execution-unit writeback interface: consumes the `output_register` / `output_register_data` pair driven by execution units such as auipc.
- Holds the architectural integer register file, with two read ports and optional write-to-read bypass.
- Keeps a per-register busy scoreboard so decode can stall on pending results.
- Sits between the execution units and decode/issue.

Parameters:
XLEN, 32, data width in bits
REG_SELECT_LEN, 5, register select width
REG_COUNT, 32, number of architectural registers; must equal 2**REG_SELECT_LEN
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
wb_valid  in  1  writeback strobe; qualifies wb_register/wb_data, which may be hi-Z when low
wb_register  in  REG_SELECT_LEN  destination register (from unit output_register)
wb_data  in  XLEN  result value (from unit output_register_data)
issue_valid  in  1  decode requests to reserve destination issue_rd
issue_rd  in  REG_SELECT_LEN  destination being reserved
issue_ready  out  1  reservation accepted this cycle
flush  in  1  clear all busy bits (pipeline squash); register contents untouched
rs1_select  in  REG_SELECT_LEN  read port 1 address
rs1_data  out  XLEN  read port 1 data
rs1_busy  out  1  rs1 has a pending, unwritten result
rs2_select  in  REG_SELECT_LEN  read port 2 address
rs2_data  out  XLEN  read port 2 data
rs2_busy  out  1  rs2 has a pending, unwritten result

Behaviour:
- Reset (rst high at a clk edge): all registers become 0, all busy bits clear.
  - Outputs after reset: rs1_data/rs2_data = 0, rs1_busy/rs2_busy = 0, issue_ready = 1 whenever issue_valid is asserted.
  - Reset overrides wb_valid, issue_valid and flush in the same cycle. Reset mid-stream discards any pending writeback.
- Write: on a clk edge with wb_valid=1 and wb_register!=0, regs[wb_register] <= wb_data and busy[wb_register] <= 0. Write latency 1 cycle.
- Writeback is accepted unconditionally; there is no backpressure toward execution units.
- x0: writes ignored, reads return 0, busy[0] never set, rsN_busy=0 for select 0.
- While wb_valid=0, wb_register/wb_data may be X/Z; no state may depend on them.
- Reads are combinational from the selects:
  - If BYPASS=1, wb_valid=1 and wb_register==rsN_select!=0, rsN_data = wb_data and rsN_busy = 0.
  - Otherwise rsN_data = regs[rsN_select] and rsN_busy = busy[rsN_select].
- Scoreboard issue: issue_ready = issue_valid & (issue_rd==0 | !busy[issue_rd] | (wb_valid & wb_register==issue_rd)) & !flush.
  - Stalls on WAW.
  - A same-cycle writeback to the same register frees it.
- On a clk edge with issue_ready=1 and issue_rd!=0, busy[issue_rd] <= 1.
- Priority on the same register in one cycle:
  - reset > flush > issue set > writeback clear.
  - Simultaneous accepted issue and writeback to register R: regs[R] takes wb_data and busy[R] ends at 1 (the new reservation is pending).
- Flush: all busy bits <= 0 at the edge; issue_ready forced 0 that cycle. A writeback in a flush cycle still updates regs.
- Writeback to a non-busy register is legal: data written, busy stays 0.
- Both read ports may select the same register; both return identical data.

Decomposition:
- Shared package `riscv_pkg`:
  - XLEN and REG_SELECT_LEN constants.
  - `reg_sel_t` (logic [REG_SELECT_LEN-1:0]) and `xlen_t` (logic [XLEN-1:0]) typedefs.
  - `REG_ZERO` constant.
- One natural sub-module, `scoreboard`:
  - Contains the busy vector with set/clear/flush priority and produces issue_ready.
  - rs1_busy/rs2_busy are the raw busy lookups; the bypass override is applied in the top.
- Storage array and read muxes stay in the top.

Test Plan:
- Reset: hold rst 2 cycles with wb_valid=1, wb_register=5, wb_data=32'hDEADBEEF -> after release rs1_select=5 reads 0, rs1_busy=0.
- Write/read and bypass (BYPASS=1): wb_valid=1, wb_register=3, wb_data=32'h12345000; same cycle rs1_select=3 -> rs1_data=32'h12345000 combinationally. Next cycle with wb_valid=0 -> still 32'h12345000.
- x0: writeback wb_register=0, wb_data=32'hFFFFFFFF; issue_valid=1, issue_rd=0 -> rs2_select=0 reads 0, rs2_busy=0, issue_ready=1.
- Scoreboard WAW: issue rd=7 accepted -> rs1_busy(7)=1. A second issue of rd=7 -> issue_ready=0. Writeback rd=7 with 32'hA5A5A5A5 in the same cycle as a third issue of rd=7 -> issue_ready=1, regs[7]=32'hA5A5A5A5, busy[7]=1 afterwards.
- Flush: busy set on x1, x2, x31; flush=1 with issue_valid=1, issue_rd=4 -> issue_ready=0. Next cycle all busy=0 and busy[4]=0.
- Hi-Z tolerance: wb_valid=0 with wb_register/wb_data driven Z/X for 10 cycles -> no register or busy bit changes, no X on rs1_data/rs2_data.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V integer-datapath definitions.
//   XLEN           : integer data width
//   REG_SELECT_LEN : register select width
//   xlen_t         : one integer datum
//   reg_sel_t      : one register select
//   REG_ZERO       : select of the hard-wired zero register x0
package riscv_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned REG_SELECT_LEN = 5;

  typedef logic [XLEN-1:0]           xlen_t;
  typedef logic [REG_SELECT_LEN-1:0] reg_sel_t;

  localparam reg_sel_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_writeback_scoreboard.sv
// Busy scoreboard for the integer register file.
// Tracks one busy bit per architectural register so decode can stall on
// results that have been reserved but not yet written back.
//   clk, rst                  : clock, synchronous active-high reset
//   issue_valid, issue_rd     : reservation request from decode
//   issue_ready               : reservation accepted this cycle
//   wb_valid, wb_register     : writeback that retires a reservation
//   flush                     : clear every busy bit, refuse issue this cycle
//   rs1_select, rs1_busy      : raw busy lookup, read port 1
//   rs2_select, rs2_busy      : raw busy lookup, read port 2
module scoreboard #(
  parameter int unsigned REG_SELECT_LEN = riscv_pkg::REG_SELECT_LEN,
  parameter int unsigned REG_COUNT      = 2 ** REG_SELECT_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [REG_SELECT_LEN-1:0] issue_rd,
  output logic                      issue_ready,
  input  logic                      wb_valid,
  input  logic [REG_SELECT_LEN-1:0] wb_register,
  input  logic                      flush,
  input  logic [REG_SELECT_LEN-1:0] rs1_select,
  output logic                      rs1_busy,
  input  logic [REG_SELECT_LEN-1:0] rs2_select,
  output logic                      rs2_busy
);

  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic                 wb_frees_rd;

  // wb_register may be X/Z while wb_valid is low; wb_valid gates every use.
  assign wb_frees_rd = wb_valid && (wb_register == issue_rd);

  assign issue_ready = issue_valid && !flush &&
                       ((issue_rd == '0) || !busy_q[issue_rd] || wb_frees_rd);

  assign rs1_busy = busy_q[rs1_select];
  assign rs2_busy = busy_q[rs2_select];

  // Later assignments win: writeback clear < issue set < flush.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid && (wb_register != '0)) begin
      busy_d[wb_register] = 1'b0;
    end
    if (issue_ready && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Architectural integer register file fed by the execution-unit writeback
// interface (output_register / output_register_data).
//   clk, rst                       : clock, synchronous active-high reset
//   wb_valid, wb_register, wb_data : writeback; select/data ignored when !wb_valid
//   issue_valid, issue_rd          : destination reservation from decode
//   issue_ready                    : reservation accepted this cycle
//   flush                          : squash all reservations (data untouched)
//   rs1_select/rs1_data/rs1_busy   : read port 1
//   rs2_select/rs2_data/rs2_busy   : read port 2
// With BYPASS=1 a same-cycle writeback to a selected register is forwarded to
// the read port and masks its busy flag.
module regfile_writeback #(
  parameter int unsigned XLEN           = riscv_pkg::XLEN,
  parameter int unsigned REG_SELECT_LEN = riscv_pkg::REG_SELECT_LEN,
  parameter int unsigned REG_COUNT      = 2 ** REG_SELECT_LEN,
  parameter int unsigned BYPASS         = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  input  logic [REG_SELECT_LEN-1:0] wb_register,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      issue_valid,
  input  logic [REG_SELECT_LEN-1:0] issue_rd,
  output logic                      issue_ready,
  input  logic                      flush,
  input  logic [REG_SELECT_LEN-1:0] rs1_select,
  output logic [XLEN-1:0]           rs1_data,
  output logic                      rs1_busy,
  input  logic [REG_SELECT_LEN-1:0] rs2_select,
  output logic [XLEN-1:0]           rs2_data,
  output logic                      rs2_busy
);

  logic [XLEN-1:0] regs_q [REG_COUNT];
  logic [XLEN-1:0] regs_d [REG_COUNT];
  logic            rs1_busy_raw, rs2_busy_raw;
  logic            rs1_fwd, rs2_fwd;

  scoreboard #(
    .REG_SELECT_LEN (REG_SELECT_LEN),
    .REG_COUNT      (REG_COUNT)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_register (wb_register),
    .flush       (flush),
    .rs1_select  (rs1_select),
    .rs1_busy    (rs1_busy_raw),
    .rs2_select  (rs2_select),
    .rs2_busy    (rs2_busy_raw)
  );

  // x0 is never written, so regs_q[0] stays zero and needs no read special case.
  always_comb begin
    regs_d = regs_q;
    if (wb_valid && (wb_register != '0)) begin
      regs_d[wb_register] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rs1_fwd = (BYPASS != 0) && wb_valid && (rs1_select != '0) &&
                   (wb_register == rs1_select);
  assign rs2_fwd = (BYPASS != 0) && wb_valid && (rs2_select != '0) &&
                   (wb_register == rs2_select);

  always_comb begin
    rs1_data = regs_q[rs1_select];
    rs1_busy = rs1_busy_raw;
    if (rs1_fwd) begin
      rs1_data = wb_data;
      rs1_busy = 1'b0;
    end
  end

  always_comb begin
    rs2_data = regs_q[rs2_select];
    rs2_busy = rs2_busy_raw;
    if (rs2_fwd) begin
      rs2_data = wb_data;
      rs2_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  import riscv_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     wb_valid;
  reg_sel_t wb_register;
  xlen_t    wb_data;
  logic     issue_valid;
  reg_sel_t issue_rd;
  logic     issue_ready;
  logic     flush;
  reg_sel_t rs1_select;
  xlen_t    rs1_data;
  logic     rs1_busy;
  reg_sel_t rs2_select;
  xlen_t    rs2_data;
  logic     rs2_busy;

  regfile_writeback #(
    .XLEN           (XLEN),
    .REG_SELECT_LEN (REG_SELECT_LEN),
    .REG_COUNT      (32),
    .BYPASS         (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_register (wb_register),
    .wb_data     (wb_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .flush       (flush),
    .rs1_select  (rs1_select),
    .rs1_data    (rs1_data),
    .rs1_busy    (rs1_busy),
    .rs2_select  (rs2_select),
    .rs2_data    (rs2_data),
    .rs2_busy    (rs2_busy)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: what a port should show, pushed when stimulus is driven.
  typedef struct {
    string name;
    xlen_t value;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  e;
  int    n_cmp = 0;
  int    n_err = 0;
  xlen_t model_regs [32];
  logic  model_busy [32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid    = 1'b0;
    wb_register = '0;
    wb_data     = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    flush       = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    wb_valid    = 1'b1;
    wb_register = 5'd5;
    wb_data     = 32'hDEADBEEF;
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    flush       = 1'b0;
    rs1_select  = 5'd5;
    rs2_select  = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    idle_inputs();
    exp_q.push_back('{"reset_rs1_data", 32'h0});
    exp_q.push_back('{"reset_rs1_busy", 32'h0});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.value) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.name, rs1_data, e.value);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, rs1_busy} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, rs1_busy, e.value);
    end
    // issue_ready must follow issue_valid out of reset (combinational, no edge taken).
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    exp_q.push_back('{"reset_issue_ready", 32'h1});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, issue_ready} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, issue_ready, e.value);
    end
    issue_valid = 1'b0;
  endtask

  task automatic test_write_bypass();
    wb_valid    = 1'b1;
    wb_register = 5'd3;
    wb_data     = 32'h12345000;
    rs1_select  = 5'd3;
    rs2_select  = 5'd3;
    exp_q.push_back('{"bypass_rs1_data", 32'h12345000});
    exp_q.push_back('{"bypass_rs2_data", 32'h12345000});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.value) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.name, rs1_data, e.value);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (rs2_data !== e.value) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.name, rs2_data, e.value);
    end
    model_regs[3] = 32'h12345000;
    tick();
    wb_valid = 1'b0;
    exp_q.push_back('{"stored_rs1_data", model_regs[3]});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.value) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.name, rs1_data, e.value);
    end
  endtask

  task automatic test_x0();
    wb_valid    = 1'b1;
    wb_register = REG_ZERO;
    wb_data     = 32'hFFFFFFFF;
    issue_valid = 1'b1;
    issue_rd    = REG_ZERO;
    rs2_select  = REG_ZERO;
    exp_q.push_back('{"x0_issue_ready", 32'h1});
    exp_q.push_back('{"x0_rs2_data_bypass", 32'h0});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, issue_ready} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, issue_ready, e.value);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (rs2_data !== e.value) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.name, rs2_data, e.value);
    end
    tick();
    idle_inputs();
    exp_q.push_back('{"x0_rs2_data", 32'h0});
    exp_q.push_back('{"x0_rs2_busy", 32'h0});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs2_data !== e.value) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.name, rs2_data, e.value);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, rs2_busy} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, rs2_busy, e.value);
    end
  endtask

  task automatic test_waw();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    rs1_select  = 5'd7;
    exp_q.push_back('{"waw_first_issue", 32'h1});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, issue_ready} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, issue_ready, e.value);
    end
    tick();
    model_busy[7] = 1'b1;
    // Second reservation of x7 with no writeback must stall.
    exp_q.push_back('{"waw_busy_set", 32'h1});
    exp_q.push_back('{"waw_second_issue", 32'h0});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, rs1_busy} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, rs1_busy, e.value);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, issue_ready} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, issue_ready, e.value);
    end
    tick();
    // Writeback frees x7 in the same cycle as a third reservation.
    wb_valid    = 1'b1;
    wb_register = 5'd7;
    wb_data     = 32'hA5A5A5A5;
    exp_q.push_back('{"waw_third_issue", 32'h1});
    exp_q.push_back('{"waw_fwd_busy", 32'h0});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, issue_ready} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, issue_ready, e.value);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, rs1_busy} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, rs1_busy, e.value);
    end
    tick();
    idle_inputs();
    model_regs[7] = 32'hA5A5A5A5;
    model_busy[7] = 1'b1;
    exp_q.push_back('{"waw_data_after", model_regs[7]});
    exp_q.push_back('{"waw_busy_after", {31'b0, model_busy[7]}});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs1_data !== e.value) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.name, rs1_data, e.value);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, rs1_busy} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, rs1_busy, e.value);
    end
    // Retire the reservation so later tests start from an idle scoreboard.
    wb_valid    = 1'b1;
    wb_register = 5'd7;
    wb_data     = 32'h00000011;
    tick();
    idle_inputs();
    model_regs[7] = 32'h00000011;
    model_busy[7] = 1'b0;
    exp_q.push_back('{"waw_retired_busy", 32'h0});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, rs1_busy} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, rs1_busy, e.value);
    end
  endtask

  task automatic test_flush();
    reg_sel_t rds [3];
    rds[0] = 5'd1;
    rds[1] = 5'd2;
    rds[2] = 5'd31;
    foreach (rds[i]) begin
      issue_valid = 1'b1;
      issue_rd    = rds[i];
      tick();
      model_busy[rds[i]] = 1'b1;
    end
    issue_valid = 1'b0;
    rs1_select  = 5'd31;
    rs2_select  = 5'd1;
    exp_q.push_back('{"flush_pre_busy31", 32'h1});
    exp_q.push_back('{"flush_pre_busy1", 32'h1});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, rs1_busy} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, rs1_busy, e.value);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, rs2_busy} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, rs2_busy, e.value);
    end
    // Flush refuses issue; a writeback in the same cycle still lands.
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_rd    = 5'd4;
    wb_valid    = 1'b1;
    wb_register = 5'd10;
    wb_data     = 32'h0000CAFE;
    exp_q.push_back('{"flush_issue_ready", 32'h0});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({31'b0, issue_ready} !== e.value) begin
      n_err++;
      $display("FAIL %s: got %b expected %0h", e.name, issue_ready, e.value);
    end
    tick();
    idle_inputs();
    for (int r = 0; r < 32; r++) model_busy[r] = 1'b0;
    model_regs[10] = 32'h0000CAFE;
    for (int k = 0; k < 4; k++) begin
      rs1_select = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : (k == 2) ? 5'd31 : 5'd4;
      exp_q.push_back('{"flush_busy_cleared", 32'h0});
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({31'b0, rs1_busy} !== e.value) begin
        n_err++;
        $display("FAIL %s x%0d: got %b expected %0h", e.name, rs1_select, rs1_busy, e.value);
      end
    end
    rs2_select = 5'd10;
    exp_q.push_back('{"flush_wb_data", model_regs[10]});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (rs2_data !== e.value) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.name, rs2_data, e.value);
    end
  endtask

  task automatic test_hiz();
    wb_valid    = 1'b0;
    wb_register = 'z;
    wb_data     = 'x;
    issue_valid = 1'b0;
    flush       = 1'b0;
    repeat (10) tick();
    for (int r = 0; r < 32; r++) begin
      rs1_select = reg_sel_t'(r);
      rs2_select = reg_sel_t'(31 - r);
      exp_q.push_back('{"hiz_rs1_data", model_regs[r]});
      exp_q.push_back('{"hiz_rs2_data", model_regs[31 - r]});
      exp_q.push_back('{"hiz_rs1_busy", {31'b0, model_busy[r]}});
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (rs1_data !== e.value) begin
        n_err++;
        $display("FAIL %s x%0d: got %h expected %h", e.name, r, rs1_data, e.value);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (rs2_data !== e.value) begin
        n_err++;
        $display("FAIL %s x%0d: got %h expected %h", e.name, 31 - r, rs2_data, e.value);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if ({31'b0, rs1_busy} !== e.value) begin
        n_err++;
        $display("FAIL %s x%0d: got %b expected %0h", e.name, r, rs1_busy, e.value);
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      model_regs[r] = '0;
      model_busy[r] = 1'b0;
    end
    idle_inputs();
    rst        = 1'b0;
    rs1_select = '0;
    rs2_select = '0;
    @(negedge clk);
    test_reset();
    test_write_bypass();
    test_x0();
    test_waw();
    test_flush();
    test_hiz();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
